// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, oversampled by OVERSAMPLE rx_en ticks per bit.
// Latency: 2-clk input synchronizer; rx_valid/rx_frame_err 1 clk after the stop-bit sampling tick.
// Backpressure: none; the consumer must take rx_data within one frame. Optional UART_RX_MAJORITY_EN.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       RxD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    sync_q;
  logic          rxd_s;
  logic          rx_bit;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], RxD};
  end
  assign rxd_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Samples from the two previous ticks; with the current one they form a 3-sample vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        hist_q <= 2'b11;
    else if (rx_en) hist_q <= {hist_q[0], rxd_s};
  end
  assign rx_bit = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rx_bit = rxd_s;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: tick counting, bit sampling at mid-bit and frame checking.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_en && !rxd_s) begin
          tcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (rx_en) begin
          if (tcnt_q == HALF_M1) begin
            if (rx_bit) begin
              state_d = S_IDLE;          // glitch, not a real start bit
            end else begin
              tcnt_d  = '0;
              bcnt_d  = '0;
              state_d = S_DATA;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_DATA: begin
        if (rx_en) begin
          if (tcnt_q == FULL_M1) begin
            sr_d   = {rx_bit, sr_q[7:1]};
            tcnt_d = '0;
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = S_STOP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_STOP: begin
        if (rx_en) begin
          if (tcnt_q == FULL_M1) begin
            tcnt_d = '0;
            if (rx_bit) begin
              data_d  = sr_q;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT;          // hold off until the line recovers from a break
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      S_WAIT: begin
        if (rx_en && rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with an rx_en tick every 4 clk cycles.
// Covers reset, single and back-to-back frames, false start, framing error, reset mid-frame, glitch.
// Results are checked against hand-computed bytes and pulse counts.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int         total = 0;
  int         bad = 0;
  int         vcnt = 0;
  int         fcnt = 0;
  int         cyc = 0;
  int         busy_rise = -1;
  int         valid_at = -1;
  logic       busy_prev = 1'b0;
  logic [7:0] cap[$];
  logic [7:0] glitch_exp;

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_en        (rx_en),
    .RxD          (RxD),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt++;
      cap.push_back(rx_data);
      valid_at = cyc;
    end
    if (rx_frame_err) fcnt++;
    if (rx_busy && !busy_prev) busy_rise = cyc;
    busy_prev = rx_busy;
  end

  task automatic tick();
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    @(negedge clk);
    rx_en = 1'b0;
  endtask

  task automatic line(input logic b, input int n);
    RxD = b;
    repeat (n) tick();
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    line(1'b0, 16);
    for (int i = 0; i < 8; i++) line(d[i], 16);
    line(stop, 16);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr",  32'(rx_frame_err), 32'h0);
    chk("rst_busy",  32'(rx_busy), 32'h0);
    rst = 1'b0;
    line(1'b1, 20);

    // Single frame 0x55; stop sampled 152 ticks (608 clk) after start detection
    frame(8'h55, 1'b1);
    line(1'b1, 8);
    chk("single_cnt",  32'(vcnt), 32'd1);
    chk("single_data", 32'(cap[0]), 32'h55);
    chk("single_ferr", 32'(fcnt), 32'd0);
    chk("single_busy", 32'(rx_busy), 32'h0);
    chk("single_lat",  32'(valid_at - busy_rise), 32'd608);

    // Back-to-back frames, no idle gap
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    frame(8'hA3, 1'b1);
    line(1'b1, 8);
    chk("b2b_cnt", 32'(vcnt), 32'd4);
    chk("b2b_d0",  32'(cap[1]), 32'h00);
    chk("b2b_d1",  32'(cap[2]), 32'hFF);
    chk("b2b_d2",  32'(cap[3]), 32'hA3);

    // False start: 4-tick low pulse
    line(1'b0, 4);
    line(1'b1, 24);
    chk("fs_cnt",  32'(vcnt), 32'd4);
    chk("fs_ferr", 32'(fcnt), 32'd0);
    chk("fs_busy", 32'(rx_busy), 32'h0);
    frame(8'h3C, 1'b1);
    line(1'b1, 8);
    chk("fs_next_cnt",  32'(vcnt), 32'd5);
    chk("fs_next_data", 32'(cap[4]), 32'h3C);

    // Framing error followed by a 3-bit break
    frame(8'h12, 1'b1);
    frame(8'hA3, 1'b0);
    line(1'b0, 48);
    chk("fe_ferr",  32'(fcnt), 32'd1);
    chk("fe_cnt",   32'(vcnt), 32'd6);
    chk("fe_good",  32'(cap[5]), 32'h12);
    chk("fe_hold",  32'(rx_data), 32'h12);
    chk("fe_busy",  32'(rx_busy), 32'h1);
    line(1'b1, 20);
    chk("fe_idle",  32'(rx_busy), 32'h0);
    frame(8'h7E, 1'b1);
    line(1'b1, 8);
    chk("fe_next_cnt",  32'(vcnt), 32'd7);
    chk("fe_next_data", 32'(cap[6]), 32'h7E);
    chk("fe_next_ferr", 32'(fcnt), 32'd1);

    // Reset asserted during bit 4
    line(1'b0, 16);
    for (int i = 0; i < 4; i++) line(1'((8'hC9 >> i) & 8'h01), 16);
    RxD = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("mrst_data",  32'(rx_data), 32'h00);
    chk("mrst_valid", 32'(rx_valid), 32'h0);
    chk("mrst_ferr",  32'(rx_frame_err), 32'h0);
    chk("mrst_busy",  32'(rx_busy), 32'h0);
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    line(1'b1, 20);
    chk("mrst_cnt",   32'(vcnt), 32'd7);
    chk("mrst_fcnt",  32'(fcnt), 32'd1);
    frame(8'hC9, 1'b1);
    line(1'b1, 8);
    chk("mrst_next_cnt",  32'(vcnt), 32'd8);
    chk("mrst_next_data", 32'(cap[7]), 32'hC9);

    // 0x00 with a one-tick high glitch on the bit-3 sampling tick
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    line(1'b0, 16);
    for (int i = 0; i < 3; i++) line(1'b0, 16);
    line(1'b0, 8);
    line(1'b1, 1);
    line(1'b0, 7);
    for (int i = 4; i < 8; i++) line(1'b0, 16);
    line(1'b1, 16);
    line(1'b1, 8);
    chk("glitch_cnt",  32'(vcnt), 32'd9);
    chk("glitch_data", 32'(cap[8]), 32'(glitch_exp));
    chk("glitch_ferr", 32'(fcnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

RS-232 serial receiver: recovers 8N1 frames (1 start, 8 data LSB first, 1 stop) from the asynchronous `RxD` line and presents each byte as a parallel word with a single-cycle valid strobe. It is the receive-side counterpart of the lab's UART TX unit and shares its external baud-tick generator. The receiver runs at an oversampled tick rate so that it can align to the start-bit edge and sample each bit near its centre.

## Interface
- `OVERSAMPLE`, 16: `rx_en` ticks per bit period. Must be even and at least 4.

- `clk` input 1: on-board 100 MHz system clock.
- `rst` input 1: asynchronous, active-high reset.
- `rx_en` input 1: oversampling tick, a single-clock pulse at baud × `OVERSAMPLE` (9600 × 16 = 153.6 kHz). Never asserted on two consecutive cycles.
- `RxD` input 1: asynchronous serial input; idles high.
- `rx_data` output 8: last correctly framed byte.
- `rx_valid` output 1: single-clock pulse; `rx_data` is new on that cycle.
- `rx_frame_err` output 1: single-clock pulse; stop bit was sampled low.
- `rx_busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer:** `RxD` passes through a 2-FF synchronizer (both flops reset to 1) to produce `rxd_s`. All decisions use `rxd_s`; nothing uses raw `RxD`.
- **Bit decision (`rx_bit`):** the value taken at a sampling tick. Without the macro it is `rxd_s`; see Configuration for the alternative.
- **Registers:** tick counter `tcnt`, width $clog2(`OVERSAMPLE`), advanced only on `rx_en`; bit index `bcnt` (0..7); shift register `sr[7:0]`.
- **FSM states:**
  - **IDLE:** on `rx_en` with `rxd_s`=0, clear `tcnt` and go to START.
  - **START:** on `rx_en`, increment `tcnt`. At the tick where `tcnt`=`OVERSAMPLE`/2−1:
    - if `rx_bit`=1, treat it as a false start and go to IDLE;
    - otherwise clear `tcnt` and `bcnt` and go to DATA.
  - **DATA:** on `rx_en`, increment `tcnt`. At `tcnt`=`OVERSAMPLE`−1:
    - shift right with `sr` <= {`rx_bit`, `sr[7:1]`}, clear `tcnt`, increment `bcnt`;
    - after the 8th bit (`bcnt`=7) go to STOP.
  - **STOP:** at `tcnt`=`OVERSAMPLE`−1:
    - if `rx_bit`=1: `rx_data` <= `sr`, pulse `rx_valid`, go to IDLE;
    - if `rx_bit`=0: pulse `rx_frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** on `rx_en` with `rxd_s`=1, go to IDLE. This prevents a held-low line (break) from retriggering start detection.
- **Unused encodings:** any unused state encoding goes to IDLE.
- **Reset values (asynchronous):**
  - FSM in IDLE; `tcnt`, `bcnt` and `sr` cleared.
  - `rx_data`=8'h00, `rx_valid`=0, `rx_frame_err`=0, `rx_busy`=0.
  - Synchronizer flops and majority history reset to 1.
- **Reset mid-frame:** the partial byte is discarded with no pulse on any output, and reception resumes on the next falling edge after reset is released.

## Timing
- **Synchronizer latency:** 2 `clk` cycles from `RxD` to `rxd_s`.
- **Start alignment:** the start bit is first seen at the first `rx_en` tick with `rxd_s`=0, so there is up to 1 tick of alignment error. Sampling points sit at `OVERSAMPLE`/2 ticks after detection, then every `OVERSAMPLE` ticks.
- **Output strobes:** `rx_valid`, `rx_frame_err` and the updated `rx_data` are registered. They appear 1 `clk` cycle after the `rx_en` tick that samples the stop bit, and each pulse is exactly 1 `clk` wide.
- **Back-to-back frames:** after a good stop sample the FSM is in IDLE about half a bit before the stop bit ends, so a start bit immediately following the stop bit is caught with no frame lost.
- **No flow control:** the consumer must take `rx_data` within one frame time, about 1.04 ms at 9600 baud. `rx_data` holds its value until the next good frame.
- **`rx_busy` timing:** rises 1 `clk` after start detection and falls on the same cycle as the `rx_valid` or `rx_frame_err` pulse. On a framing error it stays high through WAIT_IDLE.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:** a 3-bit history of `rxd_s` is shifted on every `rx_en`. `rx_bit` is the majority of `rxd_s` at the current tick and the two previous ticks, so a glitch one tick wide at a sampling point is rejected. This applies to START, DATA and STOP sampling.
- **Undefined:** `rx_bit`=`rxd_s`, a single sample, and the history register is not instantiated.

## Test plan
- **Single frame:** send 0x55 at 9600 baud, `OVERSAMPLE`=16. Expect `rx_data`=0x55 and exactly one `rx_valid` pulse, about 9.5 bit times after the start edge; `rx_frame_err` stays 0.
- **Back-to-back frames:** send 0x00, 0xFF, 0xA3 with no idle gap. Expect three `rx_valid` pulses with `rx_data` equal to 0x00, 0xFF, 0xA3 in order.
- **False start:** drive a low pulse 4 ticks wide on an idle line. Expect no `rx_valid`, no `rx_frame_err`, and the FSM back in IDLE; a following 0x3C is then received correctly.
- **Framing error:** first send 0x12 correctly, then send 0xA3 with the stop bit forced to 0 and the line held low for 3 more bit times. Expect one `rx_frame_err` pulse, `rx_data` holding 0x12, and no retrigger until the line returns high; a following 0x7E is then received.
- **Reset mid-frame:** assert `rst` during bit 4 of a frame. Expect all outputs to return to their reset values immediately with no pulses; the next full 0xC9 frame is received correctly.
- **Glitch rejection:** send 0x00 with a high glitch one tick wide on the bit 3 sampling tick. Expect `rx_data`=0x00 with the macro defined, and 0x08 without it.
